// File: rtl/battleship_board.sv
// Single-player battleship board: placement phase, then in-place shot resolution
// with hit/miss marking, all-sunk detection and an independent registered read port.
module battleship_board #(
    parameter int BOARD_W   = 10,
    parameter int BOARD_H   = 10,
    parameter int MAX_SHIPS = 10,
    parameter int X_W       = $clog2(BOARD_W),
    parameter int Y_W       = $clog2(BOARD_H),
    parameter int CNT_W     = $clog2(MAX_SHIPS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             place_req,
    input  logic [X_W-1:0]   place_x,
    input  logic [Y_W-1:0]   place_y,
    output logic             place_ack,
    output logic             place_err,
    input  logic             lock,
    input  logic             shot_req,
    input  logic [X_W-1:0]   shot_x,
    input  logic [Y_W-1:0]   shot_y,
    output logic             shot_done,
    output logic [1:0]       shot_result,
    input  logic [X_W-1:0]   rd_x,
    input  logic [Y_W-1:0]   rd_y,
    output logic [1:0]       rd_code,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] ships_placed,
    output logic [CNT_W-1:0] ships_left,
    output logic             all_sunk
);

    localparam int NCELL = BOARD_W * BOARD_H;
    localparam int IW    = X_W + Y_W + 2;

    typedef enum logic [1:0] {
        PH_PLACE  = 2'b00,
        PH_BATTLE = 2'b01,
        PH_DONE   = 2'b10
    } phase_e;

    // Bit offset of a cell inside the flat packed board (2 bits per cell).
    function automatic logic [IW-1:0] cell_base(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        cell_base = (IW'(y) * IW'(BOARD_W) + IW'(x)) << 1'b1;
    endfunction

    function automatic logic in_range(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        in_range = (32'(x) < 32'(BOARD_W)) && (32'(y) < 32'(BOARD_H));
    endfunction

    logic [2*NCELL-1:0] cells_q, cells_d;
    phase_e             phase_q, phase_d;
    logic [CNT_W-1:0]   placed_q, placed_d;
    logic [CNT_W-1:0]   left_q, left_d;
    logic               ack_q, ack_d, err_q, err_d, done_q, done_d, sunk_q, sunk_d;
    logic [1:0]         result_q, result_d, rd_code_q, rd_code_d;

    logic [IW-1:0] place_base_s, shot_base_s, rd_base_s;
    logic          place_in_s, shot_in_s, rd_in_s;
    logic [1:0]    place_cell_s, shot_cell_s, rd_cell_s;

    assign place_base_s = cell_base(place_x, place_y);
    assign shot_base_s  = cell_base(shot_x, shot_y);
    assign rd_base_s    = cell_base(rd_x, rd_y);
    assign place_in_s   = in_range(place_x, place_y);
    assign shot_in_s    = in_range(shot_x, shot_y);
    assign rd_in_s      = in_range(rd_x, rd_y);
    // Out-of-range coordinates never index the board; they read as empty.
    assign place_cell_s = place_in_s ? cells_q[place_base_s +: 2] : 2'b00;
    assign shot_cell_s  = shot_in_s  ? cells_q[shot_base_s +: 2]  : 2'b00;
    assign rd_cell_s    = rd_in_s    ? cells_q[rd_base_s +: 2]    : 2'b00;

    // Next-state: clear, placement, lock and shot resolution; reads see pre-write cells.
    always_comb begin
        cells_d   = cells_q;
        phase_d   = phase_q;
        placed_d  = placed_q;
        left_d    = left_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        done_d    = 1'b0;
        result_d  = result_q;
        rd_code_d = rd_code_q;
        sunk_d    = sunk_q;
        if (clr) begin
            cells_d   = '0;
            phase_d   = PH_PLACE;
            placed_d  = '0;
            left_d    = '0;
            result_d  = 2'b00;
            rd_code_d = 2'b00;
            sunk_d    = 1'b0;
        end else begin
            rd_code_d = rd_cell_s;
            // lock in the same cycle takes precedence over placement
            if (place_req) begin
                if ((phase_q == PH_PLACE) && !lock && place_in_s && (place_cell_s == 2'b00)
                    && (placed_q < CNT_W'(MAX_SHIPS))) begin
                    cells_d[place_base_s +: 2] = 2'b01;
                    placed_d = placed_q + CNT_W'(1);
                    ack_d    = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                ack_d = 1'b0;
            end
            if (lock && (phase_q == PH_PLACE) && (placed_q != CNT_W'(0))) begin
                phase_d = PH_BATTLE;
                left_d  = placed_q;
            end else begin
                left_d = left_d;
            end
            if (shot_req) begin
                done_d = 1'b1;
                if ((phase_q != PH_BATTLE) || !shot_in_s) begin
                    result_d = 2'b11;
                end else begin
                    case (shot_cell_s)
                        2'b01: begin
                            cells_d[shot_base_s +: 2] = 2'b11;
                            left_d   = left_q - CNT_W'(1);
                            result_d = 2'b01;
                            if (left_q == CNT_W'(1)) begin
                                phase_d = PH_DONE;
                                sunk_d  = 1'b1;
                            end else begin
                                sunk_d = sunk_q;
                            end
                        end
                        2'b00: begin
                            cells_d[shot_base_s +: 2] = 2'b10;
                            result_d = 2'b00;
                        end
                        default: result_d = 2'b10;
                    endcase
                end
            end else begin
                done_d = 1'b0;
            end
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cells_q   <= '0;
            phase_q   <= PH_PLACE;
            placed_q  <= '0;
            left_q    <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= 2'b00;
            rd_code_q <= 2'b00;
            sunk_q    <= 1'b0;
        end else begin
            cells_q   <= cells_d;
            phase_q   <= phase_d;
            placed_q  <= placed_d;
            left_q    <= left_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            done_q    <= done_d;
            result_q  <= result_d;
            rd_code_q <= rd_code_d;
            sunk_q    <= sunk_d;
        end
    end

    assign place_ack    = ack_q;
    assign place_err    = err_q;
    assign shot_done    = done_q;
    assign shot_result  = result_q;
    assign rd_code      = rd_code_q;
    assign phase        = phase_q;
    assign ships_placed = placed_q;
    assign ships_left   = left_q;
    assign all_sunk     = sunk_q;

endmodule

// File: tb/tb_battleship_board.sv
// Self-checking bench for battleship_board: a 2-D array board model checked every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_battleship_board;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic       place_req = 1'b0, lock = 1'b0, shot_req = 1'b0;
    logic [3:0] place_x = 4'd0, shot_x = 4'd0, rd_x = 4'd0;
    logic [3:0] place_y = 4'd0, shot_y = 4'd0, rd_y = 4'd0;
    logic       place_ack, place_err, shot_done, all_sunk;
    logic [1:0] shot_result, rd_code, phase;
    logic [3:0] ships_placed, ships_left;

    int n_cmp = 0;
    int n_fail = 0;

    battleship_board dut (
        .clk(clk), .rst(rst), .clr(clr),
        .place_req(place_req), .place_x(place_x), .place_y(place_y),
        .place_ack(place_ack), .place_err(place_err),
        .lock(lock),
        .shot_req(shot_req), .shot_x(shot_x), .shot_y(shot_y),
        .shot_done(shot_done), .shot_result(shot_result),
        .rd_x(rd_x), .rd_y(rd_y), .rd_code(rd_code),
        .phase(phase), .ships_placed(ships_placed), .ships_left(ships_left),
        .all_sunk(all_sunk)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Board model: cell codes 0 empty, 1 ship, 2 miss, 3 hit; phase 0/1/2.
    int cell_m [10][10];
    int phase_m, placed_m, left_m, res_m, rdc_m;
    int ack_m, err_m, done_m, sunk_m;

    always @(posedge clk or posedge rst) begin
        if (rst || clr) begin
            for (int y = 0; y < 10; y++)
                for (int x = 0; x < 10; x++)
                    cell_m[y][x] <= 0;
            phase_m <= 0; placed_m <= 0; left_m <= 0; res_m <= 0; rdc_m <= 0;
            ack_m <= 0; err_m <= 0; done_m <= 0; sunk_m <= 0;
        end else begin
            rdc_m  <= (rd_x < 4'd10 && rd_y < 4'd10) ? cell_m[rd_y][rd_x] : 0;
            ack_m  <= 0;
            err_m  <= 0;
            done_m <= 0;
            if (place_req) begin
                if (phase_m == 0 && !lock && place_x < 4'd10 && place_y < 4'd10
                    && placed_m < 10 && cell_m[place_y][place_x] == 0) begin
                    cell_m[place_y][place_x] <= 1;
                    placed_m <= placed_m + 1;
                    ack_m <= 1;
                end else begin
                    err_m <= 1;
                end
            end
            if (lock && phase_m == 0 && placed_m > 0) begin
                phase_m <= 1;
                left_m  <= placed_m;
            end
            if (shot_req) begin
                done_m <= 1;
                if (phase_m != 1 || shot_x >= 4'd10 || shot_y >= 4'd10) res_m <= 3;
                else if (cell_m[shot_y][shot_x] == 1) begin
                    cell_m[shot_y][shot_x] <= 3;
                    left_m <= left_m - 1;
                    res_m  <= 1;
                    if (left_m == 1) begin
                        phase_m <= 2;
                        sunk_m  <= 1;
                    end
                end else if (cell_m[shot_y][shot_x] == 0) begin
                    cell_m[shot_y][shot_x] <= 2;
                    res_m <= 0;
                end else res_m <= 2;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("m_phase", 32'(phase), 32'(phase_m));
        chk("m_placed", 32'(ships_placed), 32'(placed_m));
        chk("m_left", 32'(ships_left), 32'(left_m));
        chk("m_ack", 32'(place_ack), 32'(ack_m));
        chk("m_err", 32'(place_err), 32'(err_m));
        chk("m_done", 32'(shot_done), 32'(done_m));
        chk("m_result", 32'(shot_result), 32'(res_m));
        chk("m_rd_code", 32'(rd_code), 32'(rdc_m));
        chk("m_sunk", 32'(all_sunk), 32'(sunk_m));
    end

    task automatic tick();
        @(posedge clk);
        #1;
        place_req = 1'b0; lock = 1'b0; shot_req = 1'b0; clr = 1'b0;
    endtask

    task automatic place(input int x, input int y);
        place_x = 4'(x); place_y = 4'(y); place_req = 1'b1;
        tick();
    endtask

    task automatic shot(input int x, input int y);
        shot_x = 4'(x); shot_y = 4'(y); shot_req = 1'b1;
        tick();
    endtask

    initial begin
        #12 rst = 1'b0;
        for (int y = 0; y < 10; y++)
            for (int x = 0; x < 10; x++) begin
                rd_x = 4'(x); rd_y = 4'(y);
                @(posedge clk); #1;
                chk("sweep_rd", 32'(rd_code), 32'd0);
            end
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_placed", 32'(ships_placed), 32'd0);

        lock = 1'b1; tick();
        chk("lock0_phase", 32'(phase), 32'd0);

        place(3, 4);
        chk("p34_ack", 32'(place_ack), 32'd1);
        chk("p34_cnt", 32'(ships_placed), 32'd1);
        place(3, 4);
        chk("p34_dup_err", 32'(place_err), 32'd1);
        chk("p34_dup_ack", 32'(place_ack), 32'd0);
        place(10, 0);
        chk("p_oor_err", 32'(place_err), 32'd1);
        for (int i = 0; i < 9; i++) place(i, 0);
        chk("p_full_cnt", 32'(ships_placed), 32'd10);
        place(9, 0);
        chk("p_11th_err", 32'(place_err), 32'd1);
        chk("p_11th_cnt", 32'(ships_placed), 32'd10);

        clr = 1'b1; tick();
        chk("clr_cnt", 32'(ships_placed), 32'd0);

        place(0, 0);
        place(9, 9);
        place_x = 4'd5; place_y = 4'd6; place_req = 1'b1; lock = 1'b1; tick();
        chk("lockplace_err", 32'(place_err), 32'd1);
        chk("lock_phase", 32'(phase), 32'd1);
        chk("lock_left", 32'(ships_left), 32'd2);

        shot(5, 5);
        chk("s55_done", 32'(shot_done), 32'd1);
        chk("s55_res", 32'(shot_result), 32'd0);
        rd_x = 4'd5; rd_y = 4'd5; tick();
        chk("rd55", 32'(rd_code), 32'd2);
        shot(0, 0);
        chk("s00_res", 32'(shot_result), 32'd1);
        chk("s00_left", 32'(ships_left), 32'd1);
        shot(0, 0);
        chk("s00_rep", 32'(shot_result), 32'd2);
        shot(15, 2);
        chk("s_oor", 32'(shot_result), 32'd3);
        place(4, 4);
        chk("p_battle_err", 32'(place_err), 32'd1);

        shot(9, 9);
        chk("s99_res", 32'(shot_result), 32'd1);
        chk("s99_done", 32'(shot_done), 32'd1);
        chk("s99_phase", 32'(phase), 32'd2);
        chk("s99_sunk", 32'(all_sunk), 32'd1);
        shot(1, 1);
        chk("s_done_phase", 32'(shot_result), 32'd3);
        place(1, 1);
        chk("p_done_err", 32'(place_err), 32'd1);

        clr = 1'b1; place_req = 1'b1; shot_req = 1'b1; place_x = 4'd1; place_y = 4'd1;
        rd_x = 4'd9; rd_y = 4'd9; tick();
        chk("clr_phase", 32'(phase), 32'd0);
        chk("clr_ack", 32'(place_ack), 32'd0);
        chk("clr_err", 32'(place_err), 32'd0);
        chk("clr_done", 32'(shot_done), 32'd0);
        chk("clr_sunk", 32'(all_sunk), 32'd0);
        tick();
        chk("clr_rd99", 32'(rd_code), 32'd0);

        place(2, 2);
        place(7, 7);
        lock = 1'b1; tick();
        shot(2, 2);
        chk("s22_res", 32'(shot_result), 32'd1);
        rd_x = 4'd2; rd_y = 4'd2; tick();
        chk("rd22_hit", 32'(rd_code), 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("arst_phase", 32'(phase), 32'd0);
        chk("arst_left", 32'(ships_left), 32'd0);
        chk("arst_placed", 32'(ships_placed), 32'd0);
        chk("arst_rd", 32'(rd_code), 32'd0);
        chk("arst_res", 32'(shot_result), 32'd0);
        @(negedge clk); #2 rst = 1'b0;
        tick();
        tick();
        chk("post_rd", 32'(rd_code), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
